// File: rtl/arith_arbiter.sv
// Two-requester arithmetic arbiter: round-robin grant onto one shared
// add/sub/mul/and datapath, one command in flight, registered response.
module arith_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [1:0]       a_op,
  input  logic [WIDTH-1:0] a_data_1,
  input  logic [WIDTH-1:0] a_data_2,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [1:0]       b_op,
  input  logic [WIDTH-1:0] b_data_1,
  input  logic [WIDTH-1:0] b_data_2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  localparam int unsigned OP_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_AND = 2'b11
  } op_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] data_1;
    logic [WIDTH-1:0] data_2;
  } cmd_t;

  state_t           state;
  state_t           state_next;
  cmd_t             a_cmd;
  cmd_t             b_cmd;
  cmd_t             cmd_q;
  logic             owner_q;
  logic             last_grant_b;
  logic             grant_a;
  logic             grant_b;
  logic             accept;
  logic [WIDTH-1:0] result;

  assign a_cmd = '{op: a_op, data_1: a_data_1, data_2: a_data_2};
  assign b_cmd = '{op: b_op, data_1: b_data_1, data_2: b_data_2};

  // Round-robin: on a tie the requester not granted last time wins.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_valid && b_valid) begin
      grant_a = last_grant_b;
      grant_b = !last_grant_b;
    end else begin
      grant_a = a_valid;
      grant_b = b_valid;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ready is only offered in IDLE, and never while reset is asserted.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!reset && state == IDLE) begin
      a_ready = grant_a;
      b_ready = grant_b;
    end
  end

  assign accept = a_ready || b_ready;

  // Command capture and grant pointer; the pointer moves only on a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_b <= 1'b1;
    end else if (accept) begin
      cmd_q        <= b_ready ? b_cmd : a_cmd;
      owner_q      <= b_ready;
      last_grant_b <= b_ready;
    end
  end

  // Shared datapath; all results wrap to WIDTH bits.
  always_comb begin
    result = '0;
    case (op_t'(cmd_q.op))
      OP_ADD:  result = cmd_q.data_1 + cmd_q.data_2;
      OP_SUB:  result = cmd_q.data_1 - cmd_q.data_2;
      OP_MUL:  result = cmd_q.data_1 * cmd_q.data_2;
      OP_AND:  result = cmd_q.data_1 & cmd_q.data_2;
      default: result = '0;
    endcase
  end

  // Response and status registers; payload loads once, at the end of EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= (state_next == RESP);
      busy      <= (state_next != IDLE);
      if (state == EXEC) begin
        rsp_data <= result;
        rsp_id   <= owner_q;
      end
    end
  end

  ready_onehot: assert property (@(posedge clk) !(a_ready && b_ready));

  no_accept_in_rsp: assert property (@(posedge clk) rsp_valid |-> !(a_ready || b_ready));

  rsp_hold: assert property (@(posedge clk) disable iff (reset)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_id)));

endmodule
